// File: rtl/ram_pkg.sv
// Shared types and helpers for the ram_2rw_be dual-port scratchpad.
package ram_pkg;

    localparam int unsigned DATA_SIZE  = 8;
    localparam int unsigned RD_LAT_MAX = 2;

    typedef logic [DATA_SIZE-1:0] mem_entry_t;

    // Number of byte lanes carried by a bus of the given width.
    function automatic int unsigned lanes(input int unsigned width);
        return width / DATA_SIZE;
    endfunction

endpackage

// File: rtl/ram_2rw_be_if.sv
// Request/response bundle for one port of ram_2rw_be.
interface ram_2rw_be_if
    import ram_pkg::*;
#(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic                 req;
    logic                 wr_en;
    logic [AW-1:0]        addr;
    logic [lanes(DW)-1:0] be;
    logic [DW-1:0]        wr_data;
    logic [DW-1:0]        rd_data;
    logic                 rd_valid;

    modport master (output req, wr_en, addr, be, wr_data, input rd_data, rd_valid);
    modport slave  (input req, wr_en, addr, be, wr_data, output rd_data, rd_valid);
endinterface

// File: rtl/ram_rd_pipe.sv
// Read-return delay line: valid and data shifted through rdLatency register stages.
module ram_rd_pipe
    import ram_pkg::*;
#(
    parameter int unsigned W         = 32,
    parameter int unsigned rdLatency = 1
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);
    localparam int unsigned STAGES = (rdLatency > RD_LAT_MAX) ? RD_LAT_MAX :
                                     (rdLatency < 1) ? 1 : rdLatency;

    logic [STAGES-1:0] v_q;
    logic [W-1:0]      d_q [STAGES];

    // Data stages load only with valid, so the last stage holds the last returned value.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            v_q <= '0;
            for (int unsigned k = 0; k < STAGES; k++) d_q[k] <= '0;
        end else begin
            v_q[0] <= in_valid;
            if (in_valid) d_q[0] <= in_data;
            for (int unsigned k = 1; k < STAGES; k++) begin
                v_q[k] <= v_q[k-1];
                if (v_q[k-1]) d_q[k] <= d_q[k-1];
            end
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign out_data  = d_q[STAGES-1];
endmodule

// File: rtl/ram_2rw_be.sv
// Dual-port byte-addressed scratchpad with byte enables, read-first reads and port 2 write priority.
// Optional collision detector enabled by `RAM_2RW_COLL_DET_EN.
module ram_2rw_be
    import ram_pkg::*;
#(
    parameter int unsigned addrWidth       = 32,
    parameter int unsigned dataSize        = DATA_SIZE,
    parameter int unsigned interfaceWidth1 = 32,
    parameter int unsigned interfaceWidth2 = 256,
    parameter int unsigned depth           = 1024,
    parameter int unsigned rdLatency       = 1,
    parameter int unsigned rdReverse       = 1
) (
    input  logic          clk,
    input  logic          nrst,
    ram_2rw_be_if.slave   p1,
    ram_2rw_be_if.slave   p2
`ifdef RAM_2RW_COLL_DET_EN
    ,
    output logic          coll_o,
    output logic [15:0]   coll_cnt_o
`endif
);
    localparam int unsigned IDX_W = $clog2(depth);
    localparam int unsigned L1    = lanes(interfaceWidth1);
    localparam int unsigned L2    = lanes(interfaceWidth2);

    mem_entry_t                 mem [depth];
    logic [IDX_W-1:0]           base1, base2;
    logic [interfaceWidth1-1:0] rd_lanes1_c;
    logic [interfaceWidth2-1:0] rd_lanes2_c;
    logic                       rd_req1_c, rd_req2_c;
    logic                       unused_addr_hi;

    assign base1 = p1.addr[IDX_W-1:0];
    assign base2 = p2.addr[IDX_W-1:0];
    assign unused_addr_hi = ^{p1.addr[addrWidth-1:IDX_W], p2.addr[addrWidth-1:IDX_W]};

    // Port 1 lanes first, port 2 second: the later assignment wins on a shared entry.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int unsigned e = 0; e < depth; e++) mem[e] <= '0;
        end else begin
            if (p1.req && p1.wr_en) begin
                for (int unsigned i = 0; i < L1; i++)
                    if (p1.be[i]) mem[base1 + IDX_W'(i)] <= p1.wr_data[i*dataSize +: dataSize];
            end
            if (p2.req && p2.wr_en) begin
                for (int unsigned i = 0; i < L2; i++)
                    if (p2.be[i]) mem[base2 + IDX_W'(i)] <= p2.wr_data[i*dataSize +: dataSize];
            end
        end
    end

    // Read lanes see pre-edge contents, giving read-first behaviour against either writer.
    always_comb begin
        rd_lanes1_c = '0;
        rd_lanes2_c = '0;
        for (int unsigned i = 0; i < L1; i++)
            rd_lanes1_c[i*dataSize +: dataSize] =
                mem[base1 + IDX_W'((rdReverse != 0) ? (L1 - 1 - i) : i)];
        for (int unsigned i = 0; i < L2; i++)
            rd_lanes2_c[i*dataSize +: dataSize] =
                mem[base2 + IDX_W'((rdReverse != 0) ? (L2 - 1 - i) : i)];
    end

    assign rd_req1_c = p1.req && !p1.wr_en;
    assign rd_req2_c = p2.req && !p2.wr_en;

    ram_rd_pipe #(.W(interfaceWidth1), .rdLatency(rdLatency)) u_rd_pipe_1 (
        .clk       (clk),
        .nrst      (nrst),
        .in_valid  (rd_req1_c),
        .in_data   (rd_lanes1_c),
        .out_valid (p1.rd_valid),
        .out_data  (p1.rd_data)
    );

    ram_rd_pipe #(.W(interfaceWidth2), .rdLatency(rdLatency)) u_rd_pipe_2 (
        .clk       (clk),
        .nrst      (nrst),
        .in_valid  (rd_req2_c),
        .in_data   (rd_lanes2_c),
        .out_valid (p2.rd_valid),
        .out_data  (p2.rd_data)
    );

`ifdef RAM_2RW_COLL_DET_EN
    logic [depth-1:0] w1_c, w2_c;

    // Per-entry write maps; any shared bit is a same-cycle dual write.
    always_comb begin
        w1_c = '0;
        w2_c = '0;
        if (p1.req && p1.wr_en)
            for (int unsigned i = 0; i < L1; i++)
                if (p1.be[i]) w1_c[base1 + IDX_W'(i)] = 1'b1;
        if (p2.req && p2.wr_en)
            for (int unsigned i = 0; i < L2; i++)
                if (p2.be[i]) w2_c[base2 + IDX_W'(i)] = 1'b1;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            coll_o     <= 1'b0;
            coll_cnt_o <= '0;
        end else begin
            coll_o <= |(w1_c & w2_c);
            if ((|(w1_c & w2_c)) && (coll_cnt_o != 16'hFFFF))
                coll_cnt_o <= coll_cnt_o + 16'd1;
        end
    end
`else
    // Port 2 priority comes from write ordering alone; no detector is built.
`endif
endmodule
